// File: rtl/pxi_bus_pkg.sv
// Shared definitions for the PXI local-bus initiator: FSM state codes,
// bus active levels, default burst/timeout limits and the length clamp.
package pxi_bus_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_TERM = 2'd3;

  // ADS#, BLAST# and READY# are all asserted low on the wire.
  localparam logic ADS_ACT   = 1'b0;
  localparam logic BLAST_ACT = 1'b0;
  localparam logic READY_ACT = 1'b0;

  localparam int DEF_MAX_BURST = 16;
  localparam int DEF_TIMEOUT   = 255;

  // A zero-length request still moves one word; oversize requests are cut to the burst limit.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_burst);
    if (len == 0) return 1;
    if (len > max_burst) return max_burst;
    return len;
  endfunction

endpackage

// File: rtl/pxi_wait_timer.sv
// Wait-state counter for one data beat; expire fires on the TIMEOUT-th consecutive wait cycle.
// Single-cycle registered count, clear has priority over increment.
module pxi_wait_timer
  import pxi_bus_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Fires in the cycle whose edge would bring the count to TIMEOUT.
  assign expire = inc & (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pxi_local_master.sv
// PXI local-bus initiator: ADS# address phase, READY#-paced data beats, BLAST# on the last beat.
// Accept-to-DONE is 3 cycles minimum; cmd_ready only in IDLE, READY# wait states stretch each beat.
module pxi_local_master
  import pxi_bus_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int LEN_W     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_wr,
  input  logic [29:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      wr_data,
  output logic             wr_data_req,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             err,
  output logic             ads,
  output logic             blast,
  output logic             lwr,
  output logic [29:0]      la,
  output logic [31:0]      ld_o,
  output logic             ld_oe,
  input  logic [31:0]      ld_i,
  input  logic             ready
);

  logic [1:0]       state;
  logic [LEN_W-1:0] rem;
  logic             accept;
  logic             beat;
  logic             wait_cyc;
  logic             timer_clr;
  logic             tmo_hit;
  logic             more;

  assign cmd_ready = (state == ST_IDLE);
  // Gated by rst so nothing is requested while the block is held in reset.
  assign accept    = cmd_valid & cmd_ready & ~rst;
  assign beat      = (state == ST_DATA) & (ready == READY_ACT);
  assign wait_cyc  = (state == ST_DATA) & (ready != READY_ACT);
  assign more      = (rem > LEN_W'(1));
  assign timer_clr = beat | (state != ST_DATA);

  // The request is combinational: it is high in the cycle whose edge samples wr_data.
  assign wr_data_req = (accept & cmd_wr) | (beat & lwr & more);

  pxi_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .inc    (wait_cyc),
    .expire (tmo_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rem      <= '0;
      ads      <= ~ADS_ACT;
      blast    <= ~BLAST_ACT;
      lwr      <= 1'b0;
      la       <= '0;
      ld_o     <= '0;
      ld_oe    <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            la    <= cmd_addr;
            lwr   <= cmd_wr;
            ads   <= ADS_ACT;
            rem   <= LEN_W'(clamp_len(32'(cmd_len), 32'(MAX_BURST)));
            state <= ST_ADDR;
            if (cmd_wr) begin
              ld_o  <= wr_data;
              ld_oe <= 1'b1;
            end
          end
        end
        ST_ADDR: begin
          ads   <= ~ADS_ACT;
          state <= ST_DATA;
          if (rem == LEN_W'(1)) blast <= BLAST_ACT;
        end
        ST_DATA: begin
          if (beat) begin
            if (!lwr) begin
              rd_data  <= ld_i;
              rd_valid <= 1'b1;
            end
            if (more) begin
              rem <= rem - LEN_W'(1);
              la  <= la + 30'd1;
              if (lwr) ld_o <= wr_data;
              if (rem == LEN_W'(2)) blast <= BLAST_ACT;
            end else begin
              blast <= ~BLAST_ACT;
              ld_oe <= 1'b0;
              done  <= 1'b1;
              state <= ST_TERM;
            end
          end else if (tmo_hit) begin
            // Abandon the stalled beat: release the bus and flag the abort.
            blast <= ~BLAST_ACT;
            ld_oe <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
            state <= ST_TERM;
          end
        end
        ST_TERM: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
